// File: rtl/t05_lcd_writer.sv
// HD44780 4-bit writer: runs the power-on init sequence, then sends accepted bytes as two nibbles plus a settle wait.
// Latency: 2*(T_SETUP+T_E+T_GAP)+wait cycles per byte; ready_o is high only in IDLE, and valid_i is ignored otherwise.
module t05_lcd_writer #(
  parameter int unsigned POR_CYCLES = 750000,
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_E        = 25,
  parameter int unsigned T_GAP      = 50,
  parameter int unsigned T_CMD      = 2500,
  parameter int unsigned T_LONG     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       rs_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       init_done_o,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_e
);

  function automatic int unsigned at_least1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned POR_N = at_least1(POR_CYCLES);
  localparam int unsigned TS_N  = at_least1(T_SETUP);
  localparam int unsigned TE_N  = at_least1(T_E);
  localparam int unsigned TG_N  = at_least1(T_GAP);
  localparam int unsigned TC_N  = at_least1(T_CMD);
  localparam int unsigned TL_N  = at_least1(T_LONG);
  localparam int unsigned CMAX  = max2(max2(max2(POR_N, TL_N), max2(TC_N, TG_N)), max2(TE_N, TS_N));
  localparam int unsigned CW    = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  // Every phase loads duration-1 on entry and leaves when the counter reaches zero.
  localparam cnt_t LD_SETUP = cnt_t'(TS_N - 1);
  localparam cnt_t LD_E     = cnt_t'(TE_N - 1);
  localparam cnt_t LD_GAP   = cnt_t'(TG_N - 1);
  localparam cnt_t LD_CMD   = cnt_t'(TC_N - 1);
  localparam cnt_t LD_LONG  = cnt_t'(TL_N - 1);
  localparam cnt_t LD_POR2  = cnt_t'((POR_N >= 2) ? (POR_N - 2) : 0);

  typedef enum logic [2:0] {
    POR_WAIT,
    IDLE,
    SETUP,
    E_HIGH,
    E_LOW,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    INIT_NIB,
    INIT_BYTE,
    RUN
  } seq_t;

  function automatic logic [3:0] init_nib(input logic [1:0] i);
    return (i == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  state_t     state_q, state_d;
  seq_t       seq_q, seq_d;
  logic [1:0] idx_q, idx_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       brs_q, brs_d;
  logic       lo_q, lo_d;
  logic       single_q, single_d;
  logic       armed_q, armed_d;
  logic [3:0] d_q, d_d;
  logic       lrs_q, lrs_d;
  logic       done_q, done_d;
  logic       e_q;
  logic       start;
  logic       long_wait;
  logic [7:0] ib;

  // Init nibbles and clear/home commands need the long settle time.
  assign long_wait = single_q || (!brs_q && ((byte_q == 8'h01) || (byte_q == 8'h02)));

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    brs_d    = brs_q;
    lo_d     = lo_q;
    single_d = single_q;
    armed_d  = armed_q;
    d_d      = d_q;
    lrs_d    = lrs_q;
    done_d   = done_q;
    start    = 1'b0;
    ib       = 8'h00;

    case (state_q)
      POR_WAIT: begin
        // The first cycle out of reset arms the counter and counts as POR cycle one.
        if (!armed_q) begin
          armed_d = 1'b1;
          if (POR_N == 1) start = 1'b1;
          else cnt_d = LD_POR2;
        end else if (cnt_q == '0) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      IDLE: begin
        if (valid_i) begin
          byte_d   = byte_i;
          brs_d    = rs_i;
          single_d = 1'b0;
          lo_d     = 1'b0;
          d_d      = byte_i[7:4];
          lrs_d    = rs_i;
          cnt_d    = LD_SETUP;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = E_HIGH;
          cnt_d   = LD_E;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      E_HIGH: begin
        if (cnt_q == '0) begin
          state_d = E_LOW;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      E_LOW: begin
        if (cnt_q == '0) begin
          if (!single_q && !lo_q) begin
            state_d = SETUP;
            cnt_d   = LD_SETUP;
            lo_d    = 1'b1;
            d_d     = byte_q[3:0];
          end else begin
            state_d = WAIT;
            cnt_d   = long_wait ? LD_LONG : LD_CMD;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          case (seq_q)
            INIT_NIB: begin
              if (idx_q == 2'd3) begin
                seq_d = INIT_BYTE;
                idx_d = 2'd0;
              end else begin
                idx_d = idx_q + 2'd1;
              end
              start = 1'b1;
            end
            INIT_BYTE: begin
              if (idx_q == 2'd3) begin
                seq_d   = RUN;
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + 2'd1;
                start = 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = POR_WAIT;
    endcase

    // Launch the next power-on step selected by seq_d/idx_d.
    if (start) begin
      state_d = SETUP;
      cnt_d   = LD_SETUP;
      lo_d    = 1'b0;
      brs_d   = 1'b0;
      lrs_d   = 1'b0;
      if (seq_d == INIT_NIB) begin
        single_d = 1'b1;
        d_d      = init_nib(idx_d);
      end else begin
        ib       = init_byte(idx_d);
        single_d = 1'b0;
        byte_d   = ib;
        d_d      = ib[7:4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= POR_WAIT;
      seq_q    <= INIT_NIB;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      byte_q   <= 8'h00;
      brs_q    <= 1'b0;
      lo_q     <= 1'b0;
      single_q <= 1'b0;
      armed_q  <= 1'b0;
      d_q      <= 4'h0;
      lrs_q    <= 1'b0;
      done_q   <= 1'b0;
      e_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      brs_q    <= brs_d;
      lo_q     <= lo_d;
      single_q <= single_d;
      armed_q  <= armed_d;
      d_q      <= d_d;
      lrs_q    <= lrs_d;
      done_q   <= done_d;
      e_q      <= (state_d == E_HIGH);
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign init_done_o = done_q;
  assign lcd_d       = d_q;
  assign lcd_rs      = lrs_q;
  assign lcd_e       = e_q;

endmodule

// File: tb/tb_t05_lcd_writer.sv
// Bench for t05_lcd_writer: a per-cycle expectation timeline built from the display protocol rules,
// checked each cycle, plus literal pins on pulse spacing, nibble values and busy lengths.
module tb_t05_lcd_writer;

  localparam int POR = 20;
  localparam int TS  = 1;
  localparam int TE  = 2;
  localparam int TG  = 1;
  localparam int TC  = 4;
  localparam int TL  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_i;
  logic       rs_i;
  logic       valid_i;
  logic       ready_o;
  logic       init_done_o;
  logic [3:0] lcd_d;
  logic       lcd_rs;
  logic       lcd_e;

  t05_lcd_writer #(
    .POR_CYCLES(POR), .T_SETUP(TS), .T_E(TE), .T_GAP(TG), .T_CMD(TC), .T_LONG(TL)
  ) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .rs_i(rs_i), .valid_i(valid_i),
    .ready_o(ready_o), .init_done_o(init_done_o),
    .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  // One entry per cycle: outputs expected at that cycle's falling edge, then inputs to drive.
  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [7:0] b;
    logic       rs;
    logic       achk;
    logic       e;
    logic       lrs;
    logic [3:0] d;
    logic       rdy;
    logic       done;
  } ent_t;

  ent_t q[$];

  logic [3:0] md;
  logic       mrs, mdone;
  logic       brst, bv, brs;
  logic [7:0] bb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic push(input logic e, input logic rdy);
    ent_t x;
    x.rst = brst; x.vld = bv; x.b = bb; x.rs = brs; x.achk = 1'b0;
    x.e = e; x.lrs = mrs; x.d = md; x.rdy = rdy; x.done = mdone;
    q.push_back(x);
  endtask

  task automatic push_nib(input logic [3:0] n, input logic rs);
    md = n; mrs = rs;
    repeat (TS) push(1'b0, 1'b0);
    repeat (TE) push(1'b1, 1'b0);
    repeat (TG) push(1'b0, 1'b0);
  endtask

  task automatic push_wait(input int n);
    repeat (n) push(1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rs);
    push_nib(b[7:4], rs);
    push_nib(b[3:0], rs);
    push_wait((!rs && (b == 8'h01 || b == 8'h02)) ? TL : TC);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push(1'b0, 1'b1);
  endtask

  task automatic accept(input logic [7:0] b, input logic rs);
    bv = 1'b1; bb = b; brs = rs;
    push(1'b0, 1'b1);
    bv = 1'b0;
  endtask

  // n cycles held in reset, a release cycle, then the rest of the power-on wait.
  task automatic push_reset(input int n);
    md = 4'h0; mrs = 1'b0; mdone = 1'b0;
    brst = 1'b1;
    repeat (n) push(1'b0, 1'b0);
    brst = 1'b0;
    push(1'b0, 1'b0);
    repeat (POR - 1) push(1'b0, 1'b0);
  endtask

  task automatic push_init();
    logic [3:0] nibs [4];
    logic [7:0] cmds [4];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    cmds = '{8'h28, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++) begin
      push_nib(nibs[i], 1'b0);
      push_wait(TL);
    end
    for (int i = 0; i < 4; i++) push_byte(cmds[i], 1'b0);
    mdone = 1'b1;
  endtask

  task automatic build();
    brst = 1'b1; bv = 1'b0; bb = 8'h00; brs = 1'b0;
    md = 4'h0; mrs = 1'b0; mdone = 1'b0;
    // Sender holds 'A' through reset and init; it must be taken on the first ready cycle.
    bv = 1'b1; bb = 8'h41; brs = 1'b1;
    push_reset(3);
    push_init();
    accept(8'h41, 1'b1);
    push_byte(8'h41, 1'b1);
    push_idle(2);
    accept(8'h01, 1'b0);
    push_byte(8'h01, 1'b0);
    push_idle(1);
    accept(8'h01, 1'b1);
    push_byte(8'h01, 1'b1);
    push_idle(2);
    accept(8'h48, 1'b1);
    bv = 1'b1; bb = 8'h49; brs = 1'b1;
    push_byte(8'h48, 1'b1);
    accept(8'h49, 1'b1);
    push_byte(8'h49, 1'b1);
    push_idle(2);
    // Reset lands on the first E-high cycle of a data byte.
    accept(8'h5A, 1'b1);
    md = 4'h5; mrs = 1'b1;
    repeat (TS) push(1'b0, 1'b0);
    brst = 1'b1;
    push(1'b1, 1'b0);
    q[q.size()-1].achk = 1'b1;
    push_reset(2);
    push_init();
    push_idle(3);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  int         rise_si[$];
  logic [3:0] rise_d[$];
  int         runs[$];

  initial begin
    ent_t       x;
    int         si, rel_si, run_len;
    logic       counting, prev_e, prev_rs, prev_rdy;
    logic [3:0] prev_d;
    logic [3:0] exp_d [12];
    int         exp_runs [5];

    exp_d    = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    exp_runs = '{12, 18, 12, 12, 12};

    rst = 1'b1; valid_i = 1'b0; byte_i = 8'h00; rs_i = 1'b0;
    build();
    si = 0; rel_si = -1; run_len = 0; counting = 1'b0;
    prev_e = 1'b0; prev_rs = 1'b0; prev_rdy = 1'b0; prev_d = 4'h0;

    while (q.size() > 0) begin
      x = q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ({lcd_e, lcd_rs, lcd_d, ready_o, init_done_o} !== {x.e, x.lrs, x.d, x.rdy, x.done}) begin
        n_bad++;
        $display("FAIL cycle %0d e/rs/d/rdy/done: got %b %b %h %b %b, want %b %b %h %b %b",
                 si, lcd_e, lcd_rs, lcd_d, ready_o, init_done_o, x.e, x.lrs, x.d, x.rdy, x.done);
      end
      if (prev_e && lcd_e) begin
        n_cmp++;
        if (lcd_d !== prev_d || lcd_rs !== prev_rs) begin
          n_bad++;
          $display("FAIL cycle %0d bus_stable_during_e: got d=%h rs=%b, want d=%h rs=%b",
                   si, lcd_d, lcd_rs, prev_d, prev_rs);
        end
      end
      if (!prev_e && lcd_e === 1'b1) begin
        rise_si.push_back(si);
        rise_d.push_back(lcd_d);
      end
      if (counting) begin
        if (ready_o === 1'b1) begin
          runs.push_back(run_len);
          counting = 1'b0;
        end else begin
          run_len++;
        end
      end else if (prev_rdy && ready_o === 1'b0) begin
        counting = 1'b1;
        run_len = 1;
      end
      prev_e = lcd_e; prev_d = lcd_d; prev_rs = lcd_rs; prev_rdy = ready_o;

      if (x.rst) counting = 1'b0;
      if (!x.rst && rst && rel_si < 0) rel_si = si;
      rst = x.rst; valid_i = x.vld; byte_i = x.b; rs_i = x.rs;
      if (x.achk) begin
        #1;
        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_d, ready_o, init_done_o} !== 8'b0) begin
          n_bad++;
          $display("FAIL async_reset: got e=%b rs=%b d=%h rdy=%b done=%b, want all zero",
                   lcd_e, lcd_rs, lcd_d, ready_o, init_done_o);
        end
        prev_e = 1'b0;
      end
      si++;
    end

    if (rise_si.size() >= 12) begin
      chk("first_e_rise_after_release", rise_si[0] - rel_si, 21);
      chk("init_nibble_rise_spacing", rise_si[1] - rise_si[0], 14);
      chk("last_nibble_to_first_byte_spacing", rise_si[4] - rise_si[3], 14);
      chk("hi_to_lo_nibble_spacing", rise_si[5] - rise_si[4], 4);
      chk("byte_cmd_wait_spacing", rise_si[6] - rise_si[5], 8);
      chk("clear_long_wait_spacing", rise_si[10] - rise_si[9], 14);
      for (int i = 0; i < 12; i++) chk($sformatf("init_nibble_%0d", i), rise_d[i], exp_d[i]);
    end else begin
      chk("init_e_rise_count", rise_si.size(), 12);
    end
    if (runs.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("busy_cycles_byte_%0d", i), runs[i], exp_runs[i]);
    end else begin
      chk("busy_run_count", runs.size(), 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
